// File: rtl/bit_paridade_pkg.sv
// bit_paridade_pkg: shared constants and the even-parity helper for the parity checker
package bit_paridade_pkg;
  localparam int CNT_W_DEFAULT = 8;
  localparam int WORD_W = 6;
  function automatic logic parity_err(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction
endpackage

// File: rtl/bit_paridade_if.sv
// bit_paridade_if: word/parity input and check-result bus; master drives B1..B5/bitparidade/in_valid, slave returns saida/out_valid/erro_sticky/erro_cnt
interface bit_paridade_if
  import bit_paridade_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) ();
  logic B1;
  logic B2;
  logic B3;
  logic B4;
  logic B5;
  logic bitparidade;
  logic in_valid;
  logic saida;
  logic out_valid;
  logic erro_sticky;
  logic [CNT_W-1:0] erro_cnt;
  modport master (
    output B1, B2, B3, B4, B5, bitparidade, in_valid,
    input  saida, out_valid, erro_sticky, erro_cnt
  );
  modport slave (
    input  B1, B2, B3, B4, B5, bitparidade, in_valid,
    output saida, out_valid, erro_sticky, erro_cnt
  );
endinterface

// File: rtl/bit_paridade_parity_xor6.sv
// parity_xor6: combinational 6-input XOR; err=1 when the word plus its even-parity bit has odd weight (d -> err)
module parity_xor6
  import bit_paridade_pkg::*;
(
  input  logic [WORD_W-1:0] d,
  output logic              err
);
  assign err = parity_err(d);
endmodule

// File: rtl/bit_paridade.sv
// bit_paridade: registered even-parity checker (clk, rst, bus slave) with sticky error flag and saturating error counter
module bit_paridade
  import bit_paridade_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  bit_paridade_if.slave bus
);
  logic err;
  parity_xor6 u_xor (
    .d  ({bus.B1, bus.B2, bus.B3, bus.B4, bus.B5, bus.bitparidade}),
    .err(err)
  );
  // every data-dependent update is gated by in_valid so idle-cycle data never reaches state
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.saida       <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.erro_sticky <= 1'b0;
      bus.erro_cnt    <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.saida <= ~err;
        if (err) begin
          bus.erro_sticky <= 1'b1;
          bus.erro_cnt    <= (&bus.erro_cnt) ? bus.erro_cnt : bus.erro_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bit_paridade.sv
// tb_bit_paridade: scoreboard bench driving CNT_W=8 and CNT_W=2 checkers with identical stimulus
module tb_bit_paridade;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {
    logic s;
    logic ov;
    logic st;
    int   c8;
    int   c2;
  } exp_t;
  exp_t q[$];
  logic m_s = 1'b1;
  logic m_st = 1'b0;
  int   m_c8 = 0;
  int   m_c2 = 0;
  bit_paridade_if #(.CNT_W(8)) if8 ();
  bit_paridade_if #(.CNT_W(2)) if2 ();
  bit_paridade #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  bit_paridade #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  task automatic step(input logic [4:0] b, input logic p, input logic v, input logic r);
    exp_t e;
    logic ok;
    {if8.B1, if8.B2, if8.B3, if8.B4, if8.B5} = b;
    {if2.B1, if2.B2, if2.B3, if2.B4, if2.B5} = b;
    if8.bitparidade = p;
    if2.bitparidade = p;
    if8.in_valid = v;
    if2.in_valid = v;
    rst = r;
    ok = (($countones(b) + int'(p)) % 2) == 0;
    if (r) begin
      m_s = 1'b1;
      m_st = 1'b0;
      m_c8 = 0;
      m_c2 = 0;
    end else if (v) begin
      m_s = ok;
      if (!ok) begin
        m_st = 1'b1;
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
    end
    e.s = m_s;
    e.ov = v && !r;
    e.st = m_st;
    e.c8 = m_c8;
    e.c2 = m_c2;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("saida", int'(if8.saida), int'(e.s));
    chk("out_valid", int'(if8.out_valid), int'(e.ov));
    chk("erro_sticky", int'(if8.erro_sticky), int'(e.st));
    chk("erro_cnt", int'(if8.erro_cnt), e.c8);
    chk("saida_w2", int'(if2.saida), int'(e.s));
    chk("erro_sticky_w2", int'(if2.erro_sticky), int'(e.st));
    chk("erro_cnt_w2", int'(if2.erro_cnt), e.c2);
  endtask
  initial begin
    step(5'b00000, 1'b0, 1'b0, 1'b1);
    step(5'b10101, 1'b0, 1'b1, 1'b1);
    step(5'b00000, 1'b0, 1'b1, 1'b0);
    step(5'b11111, 1'b1, 1'b1, 1'b0);
    step(5'b10110, 1'b1, 1'b1, 1'b0);
    step(5'b10000, 1'b1, 1'b1, 1'b0);
    step(5'b11000, 1'b0, 1'b1, 1'b0);
    step(5'b10101, 1'b0, 1'b1, 1'b0);
    step(5'b10110, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(5'($urandom), 1'($urandom), 1'b0, 1'b0);
    step(5'b10101, 1'b0, 1'b1, 1'b1);
    step(5'b10101, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(5'b00001, 1'b0, 1'b1, 1'b0);
    step(5'b00011, 1'b0, 1'b1, 1'b0);
    step(5'b11111, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      step(5'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bit_paridade.md
BIT_PARIDADE -- requirements
Module: bit_paridade

Interface
REQ-001 Parameter CNT_W, default 8, width of the parity-error counter (legal range 1..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 B1  input  1  data bit 1 of the 5-bit word.
REQ-005 B2  input  1  data bit 2.
REQ-006 B3  input  1  data bit 3.
REQ-007 B4  input  1  data bit 4.
REQ-008 B5  input  1  data bit 5.
REQ-009 bitparidade  input  1  received even-parity bit accompanying B1..B5.
REQ-010 in_valid  input  1  B1..B5 and bitparidade are valid this cycle.
REQ-011 saida  output  1  registered check result: 1 = parity OK, 0 = parity error.
REQ-012 out_valid  output  1  saida holds a fresh result this cycle.
REQ-013 erro_sticky  output  1  set on any detected parity error; cleared only by reset.
REQ-014 erro_cnt  output  CNT_W  saturating count of detected parity errors.

Function
REQ-015 Parity scheme SHALL be even: word valid iff B1^B2^B3^B4^B5^bitparidade == 0.
REQ-016 ok = ~(B1^B2^B3^B4^B5^bitparidade), computed combinationally.
REQ-017 When in_valid=1 at a rising edge, saida SHALL take ok on that edge (1-cycle latency) and out_valid SHALL be 1 for the following cycle.
REQ-018 When in_valid=0, out_valid SHALL be 0 next cycle and saida SHALL hold its previous value.
REQ-019 No backpressure: one result accepted per cycle; back-to-back in_valid SHALL yield back-to-back out_valid.
REQ-020 On an accepted word with ok=0, erro_cnt SHALL increment by 1 on the same edge, saturating at 2^CNT_W-1 (no wrap).
REQ-021 On an accepted word with ok=0, erro_sticky SHALL be set on the same edge and stay 1 until reset.
REQ-022 Words with ok=1 or in_valid=0 SHALL NOT change erro_cnt or erro_sticky.
REQ-023 Inputs are sampled only when in_valid=1; X on data while in_valid=0 SHALL NOT propagate into any state.

Reset
REQ-024 While rst=1 at a rising edge: saida=1, out_valid=0, erro_sticky=0, erro_cnt=0, regardless of in_valid.
REQ-025 A word presented with in_valid=1 on a reset edge SHALL be discarded (not counted, no out_valid).
REQ-026 First word accepted on the first edge with rst=0.

Structure
REQ-027 No shared package required; CNT_W is the only parameter, local to the module.
REQ-028 One natural sub-module: parity_xor6 (combinational 6-input XOR yielding the parity-error bit); top holds registers and counter.

Verification
REQ-029 Reset, then B=00000, bitparidade=0, in_valid=1 -> next cycle saida=1, out_valid=1, erro_cnt=0.
REQ-030 B=11111 p=1, then B=10110 p=1, then B=10000 p=1, then B=11000 p=0 (back-to-back) -> saida=1 on four consecutive cycles, erro_cnt=0.
REQ-031 B=10101 p=0, then B=10110 p=0 -> saida=0 twice, erro_cnt=2, erro_sticky=1.
REQ-032 CNT_W=2, five consecutive error words -> erro_cnt reads 1,2,3,3,3 (saturates at 3).
REQ-033 in_valid=0 with toggling data -> out_valid=0, saida, erro_cnt and erro_sticky unchanged.
REQ-034 Error word with in_valid=1 on same edge as rst=1 -> out_valid=0, erro_cnt=0, erro_sticky=0 afterward.
